// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the 16-bit ALU.
// Accepts one operation on a valid/ready command port, pulses the enable of
// the selected sub-unit for one cycle, waits for that unit's flag (with a
// timeout), then holds the captured result on a valid/ready result port.
// Optional build macro: ALU_SEQ_PERF_CNT_EN adds OP_COUNT / ERR_COUNT outputs.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 8,
  parameter int TO_CNT_W   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [DATA_WIDTH-1:0] CMD_A,
  input  logic [DATA_WIDTH-1:0] CMD_B,
  input  logic [3:0]            CMD_FUN,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [1:0]            ALU_FUN,
  output logic                  Arith_Enable,
  output logic                  Logic_Enable,
  output logic                  CMP_Enable,
  output logic                  SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0]  Arith_OUT,
  input  logic [OUT_WIDTH-1:0]  Logic_OUT,
  input  logic [OUT_WIDTH-1:0]  CMP_OUT,
  input  logic [OUT_WIDTH-1:0]  SHIFT_OUT,
  input  logic                  Arith_Flag,
  input  logic                  Logic_Flag,
  input  logic                  CMP_Flag,
  input  logic                  SHIFT_Flag,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [OUT_WIDTH-1:0]  RES_DATA,
  output logic                  RES_ERR
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           OP_COUNT,
  output logic [7:0]            ERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Counter value on the last WAIT cycle before declaring a timeout.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  state_t                 state_r;
  logic [1:0]             sel_r;
  logic [TO_CNT_W-1:0]    to_cnt_r;
  logic                   sel_flag_s;
  logic [OUT_WIDTH-1:0]   sel_out_s;

  // Only the accepting state can take a new command.
  assign CMD_READY = (state_r == IDLE);

  // Route the flag and result of the selected unit; all others are ignored.
  always_comb begin
    sel_flag_s = 1'b0;
    sel_out_s  = {OUT_WIDTH{1'b0}};
    case (sel_r)
      2'b00: begin
        sel_flag_s = Arith_Flag;
        sel_out_s  = Arith_OUT;
      end
      2'b01: begin
        sel_flag_s = Logic_Flag;
        sel_out_s  = Logic_OUT;
      end
      2'b10: begin
        sel_flag_s = CMP_Flag;
        sel_out_s  = CMP_OUT;
      end
      2'b11: begin
        sel_flag_s = SHIFT_Flag;
        sel_out_s  = SHIFT_OUT;
      end
      default: begin
        sel_flag_s = 1'b0;
        sel_out_s  = {OUT_WIDTH{1'b0}};
      end
    endcase
  end

  // Sequencer FSM with all registered outputs; reset abandons any operation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= IDLE;
      sel_r        <= 2'b00;
      to_cnt_r     <= {TO_CNT_W{1'b0}};
      A            <= {DATA_WIDTH{1'b0}};
      B            <= {DATA_WIDTH{1'b0}};
      ALU_FUN      <= 2'b00;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      SHIFT_Enable <= 1'b0;
      RES_VALID    <= 1'b0;
      RES_DATA     <= {OUT_WIDTH{1'b0}};
      RES_ERR      <= 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
      OP_COUNT     <= 16'd0;
      ERR_COUNT    <= 8'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (CMD_VALID) begin
            A            <= CMD_A;
            B            <= CMD_B;
            ALU_FUN      <= CMD_FUN[1:0];
            sel_r        <= CMD_FUN[3:2];
            RES_ERR      <= 1'b0;
            // Enable goes high on the accept edge so it spans the ISSUE cycle.
            Arith_Enable <= (CMD_FUN[3:2] == 2'b00);
            Logic_Enable <= (CMD_FUN[3:2] == 2'b01);
            CMP_Enable   <= (CMD_FUN[3:2] == 2'b10);
            SHIFT_Enable <= (CMD_FUN[3:2] == 2'b11);
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          Arith_Enable <= 1'b0;
          Logic_Enable <= 1'b0;
          CMP_Enable   <= 1'b0;
          SHIFT_Enable <= 1'b0;
          to_cnt_r     <= {TO_CNT_W{1'b0}};
          state_r      <= WAIT;
        end
        WAIT: begin
          if (sel_flag_s) begin
            RES_DATA  <= sel_out_s;
            RES_ERR   <= 1'b0;
            RES_VALID <= 1'b1;
            state_r   <= HOLD;
          end else if (to_cnt_r == TO_LAST) begin
            // TIMEOUT flagless WAIT cycles have now elapsed.
            to_cnt_r  <= to_cnt_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
            RES_DATA  <= {OUT_WIDTH{1'b0}};
            RES_ERR   <= 1'b1;
            RES_VALID <= 1'b1;
            state_r   <= HOLD;
          end else begin
            to_cnt_r  <= to_cnt_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state_r   <= IDLE;
`ifdef ALU_SEQ_PERF_CNT_EN
            if (RES_ERR) begin
              ERR_COUNT <= ERR_COUNT + 8'd1;
            end else begin
              OP_COUNT  <= OP_COUNT + 16'd1;
            end
`endif
          end
        end
        default: begin
          Arith_Enable <= 1'b0;
          Logic_Enable <= 1'b0;
          CMP_Enable   <= 1'b0;
          SHIFT_Enable <= 1'b0;
          RES_VALID    <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a registered logic
// sub-unit model (AND, OR, XOR, NOR) and bench-driven flags for the others.
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_A = 16'h0000;
  logic [15:0] CMD_B = 16'h0000;
  logic [3:0]  CMD_FUN = 4'h0;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] Arith_OUT = 16'h0000;
  logic [15:0] Logic_OUT;
  logic [15:0] CMP_OUT = 16'h0000;
  logic [15:0] SHIFT_OUT = 16'h0000;
  logic        Arith_Flag = 1'b0;
  logic        Logic_Flag;
  logic        CMP_Flag = 1'b0;
  logic        SHIFT_Flag = 1'b0;
  logic        RES_VALID;
  logic        RES_READY = 1'b1;
  logic [15:0] RES_DATA;
  logic        RES_ERR;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] OP_COUNT;
  logic [7:0]  ERR_COUNT;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic clr_en = 1'b0;
  int cnt_arith = 0, cnt_logic = 0, cnt_cmp = 0, cnt_shift = 0;

  alu_op_sequencer dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_ERR(RES_ERR)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .OP_COUNT(OP_COUNT), .ERR_COUNT(ERR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Logic sub-unit model: registers its result and flag one cycle after enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Logic_OUT  <= 16'h0000;
      Logic_Flag <= 1'b0;
    end else begin
      Logic_Flag <= Logic_Enable;
      if (Logic_Enable) begin
        case (ALU_FUN)
          2'b00:   Logic_OUT <= A & B;
          2'b01:   Logic_OUT <= A | B;
          2'b10:   Logic_OUT <= A ^ B;
          default: Logic_OUT <= ~(A | B);
        endcase
      end
    end
  end

  // Count enable-high cycles per unit.
  always @(posedge CLK) begin
    if (clr_en) begin
      cnt_arith <= 0; cnt_logic <= 0; cnt_cmp <= 0; cnt_shift <= 0;
    end else begin
      if (Arith_Enable) cnt_arith <= cnt_arith + 1;
      if (Logic_Enable) cnt_logic <= cnt_logic + 1;
      if (CMP_Enable)   cnt_cmp   <= cnt_cmp + 1;
      if (SHIFT_Enable) cnt_shift <= cnt_shift + 1;
    end
  end

  task automatic clear_counts();
    clr_en = 1'b1;
    @(posedge CLK); #1;
    clr_en = 1'b0;
  endtask

  // Present one command and drop CMD_VALID just after the accept edge.
  task automatic issue_cmd(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    CMD_FUN = fun; CMD_A = a; CMD_B = b; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  // Edges after the accept edge until RES_VALID is seen (bounded at 20).
  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (RES_VALID) break;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2 RST = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_checks++; if ({A, B, ALU_FUN} !== 34'd0) begin n_fail++; $display("FAIL reset_operands got %h want 0", {A, B, ALU_FUN}); end
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable} !== 4'b0000) begin n_fail++; $display("FAIL reset_enables got %b want 0000", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}); end
    n_checks++; if ({RES_VALID, RES_ERR} !== 2'b00) begin n_fail++; $display("FAIL reset_res_flags got %b want 00", {RES_VALID, RES_ERR}); end
    n_checks++; if (RES_DATA !== 16'h0000) begin n_fail++; $display("FAIL reset_res_data got %h want 0000", RES_DATA); end
    n_checks++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", CMD_READY); end
    @(negedge CLK); RST = 1'b1;
  endtask

  task automatic test_logic_and();
    int lat;
    RES_READY = 1'b1;
    clear_counts();
    issue_cmd(4'b0100, 16'hF0F0, 16'h0FF0);
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable} !== 4'b0100) begin n_fail++; $display("FAIL and_issue_enables got %b want 0100", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}); end
    n_checks++; if ({A, B, ALU_FUN} !== {16'hF0F0, 16'h0FF0, 2'b00}) begin n_fail++; $display("FAIL and_latched got %h want %h", {A, B, ALU_FUN}, {16'hF0F0, 16'h0FF0, 2'b00}); end
    n_checks++; if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL and_busy_ready got %b want 0", CMD_READY); end
    wait_res(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL and_latency got %0d want 2", lat); end
    n_checks++; if (RES_DATA !== 16'h00F0) begin n_fail++; $display("FAIL and_data got %h want 00f0", RES_DATA); end
    n_checks++; if (RES_ERR !== 1'b0) begin n_fail++; $display("FAIL and_err got %b want 0", RES_ERR); end
    @(posedge CLK); #1;
    n_checks++; if ({RES_VALID, CMD_READY} !== 2'b01) begin n_fail++; $display("FAIL and_hold_exit got %b want 01", {RES_VALID, CMD_READY}); end
    n_checks++; if (cnt_logic !== 1 || cnt_arith + cnt_cmp + cnt_shift !== 0) begin n_fail++; $display("FAIL and_enable_pulses got logic=%0d others=%0d want 1/0", cnt_logic, cnt_arith + cnt_cmp + cnt_shift); end
  endtask

  task automatic test_backpressure();
    int lat;
    RES_READY = 1'b0;
    issue_cmd(4'b0111, 16'h00FF, 16'h0F00);
    wait_res(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got %0d want 2", lat); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({RES_VALID, RES_DATA, RES_ERR, CMD_READY} !== {1'b1, 16'hF000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b r=%b want v=1 d=f000 e=0 r=0", i, RES_VALID, RES_DATA, RES_ERR, CMD_READY); end
      if (i < 2) begin @(posedge CLK); #1; end
    end
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if ({RES_VALID, CMD_READY} !== 2'b01) begin n_fail++; $display("FAIL bp_release got %b want 01", {RES_VALID, CMD_READY}); end
  endtask

  task automatic test_timeout();
    int lat;
    RES_READY = 1'b1;
    clear_counts();
    issue_cmd(4'b1000, 16'h0001, 16'h0002);
    wait_res(lat);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL to_latency got %0d want 9", lat); end
    n_checks++; if ({RES_ERR, RES_DATA} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL to_result got e=%b d=%h want e=1 d=0000", RES_ERR, RES_DATA); end
    @(posedge CLK); #1;
    n_checks++; if (cnt_cmp !== 1 || cnt_arith + cnt_logic + cnt_shift !== 0) begin n_fail++; $display("FAIL to_enable_pulses got cmp=%0d others=%0d want 1/0", cnt_cmp, cnt_arith + cnt_logic + cnt_shift); end
    n_checks++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL to_idle got %b want 1", CMD_READY); end
  endtask

  task automatic test_foreign_flag();
    int lat;
    RES_READY = 1'b1;
    issue_cmd(4'b0101, 16'h1200, 16'h0034);
    @(posedge CLK); #1;
    Arith_Flag = 1'b1; Arith_OUT = 16'hDEAD;
    wait_res(lat);
    Arith_Flag = 1'b0;
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ff_latency got %0d want 1", lat); end
    n_checks++; if ({RES_DATA, RES_ERR} !== {16'h1234, 1'b0}) begin n_fail++; $display("FAIL ff_data got d=%h e=%b want d=1234 e=0", RES_DATA, RES_ERR); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    int seen;
    RES_READY = 1'b1;
    issue_cmd(4'b0010, 16'hABCD, 16'h5555);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    n_checks++; if ({A, B, ALU_FUN, RES_DATA} !== 50'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", {A, B, ALU_FUN, RES_DATA}); end
    n_checks++; if ({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable, RES_VALID, RES_ERR} !== 6'd0) begin n_fail++; $display("FAIL rst_ctrl got %b want 000000", {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable, RES_VALID, RES_ERR}); end
    @(negedge CLK); RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (RES_VALID) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_result got %0d valid cycles want 0", seen); end
    n_checks++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", CMD_READY); end
    issue_cmd(4'b0100, 16'h00FF, 16'hFF0F);
    wait_res(lat);
    n_checks++; if (lat !== 2 || RES_DATA !== 16'h000F) begin n_fail++; $display("FAIL rst_next_cmd got lat=%0d d=%h want lat=2 d=000f", lat, RES_DATA); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    RES_READY = 1'b1;
    @(negedge CLK);
    CMD_FUN = 4'b0100; CMD_A = 16'h1234; CMD_B = 16'h00FF; CMD_VALID = 1'b1;
    @(posedge CLK); #1;   // t0: first accepted
    CMD_FUN = 4'b0101;
    @(posedge CLK); #1;   // t1: ISSUE -> WAIT
    n_checks++; if (CMD_READY !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b want 0", CMD_READY); end
    @(posedge CLK); #1;   // t2: first result captured
    n_checks++; if ({RES_VALID, RES_DATA, CMD_READY} !== {1'b1, 16'h0034, 1'b0}) begin n_fail++; $display("FAIL b2b_first got v=%b d=%h r=%b want v=1 d=0034 r=0", RES_VALID, RES_DATA, CMD_READY); end
    @(posedge CLK); #1;   // t3: HOLD exit
    n_checks++; if ({RES_VALID, CMD_READY, ALU_FUN} !== {1'b0, 1'b1, 2'b00}) begin n_fail++; $display("FAIL b2b_exit got v=%b r=%b f=%b want v=0 r=1 f=00", RES_VALID, CMD_READY, ALU_FUN); end
    @(posedge CLK); #1;   // t4: second accepted
    CMD_VALID = 1'b0;
    n_checks++; if ({Logic_Enable, ALU_FUN, CMD_READY} !== {1'b1, 2'b01, 1'b0}) begin n_fail++; $display("FAIL b2b_second_issue got en=%b f=%b r=%b want en=1 f=01 r=0", Logic_Enable, ALU_FUN, CMD_READY); end
    @(posedge CLK); @(posedge CLK); #1;   // t6: second result
    n_checks++; if ({RES_VALID, RES_DATA, RES_ERR} !== {1'b1, 16'h12FF, 1'b0}) begin n_fail++; $display("FAIL b2b_second got v=%b d=%h e=%b want v=1 d=12ff e=0", RES_VALID, RES_DATA, RES_ERR); end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_logic_and();
    test_backpressure();
    test_timeout();
    test_foreign_flag();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
